owt_rx_deframe: RTL and testbench

Frame assembler directly downstream of the OWT-mode run-length symbol detector. It consumes the detector's one-cycle decoded-bit strobes, hunts for a fixed sync pattern, and shifts in a data word MSB first. It then checks even parity and either delivers the word with a one-cycle valid pulse or reports a parity or inter-bit timeout error. Consumers are the register/command layer of the one-wire receive path.

---
 rtl/owt_rx_deframe.sv | 197 +++++++++++++++++++
 tb/tb_owt_rx_deframe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/owt_rx_deframe.sv
// Purpose : one-wire receive frame assembler. It hunts for the sync pattern, shifts in DATA_W bits
//           MSB first, optionally checks even parity, and reports a good frame or an abort.
// Latency : o_frm_vld/o_frm_err are registered and pulse 1 cycle after the completing bit or the
//           timeout cycle.
// Backpr. : none. One bit per cycle at most is accepted and every strobe is consumed.
// Ports   : i_clk, i_rst_n (async active-low), i_rx_en (low aborts silently),
//           i_bit_vld/i_bit_data (decoded-bit strobe), o_frm_vld/o_frm_data (good frame),
//           o_frm_err/o_err_type (01 parity, 10 timeout), o_busy (not IDLE).
// Option  : define OWT_RX_PARITY_EN to require a trailing even-parity bit (PAR state).
module owt_rx_deframe #(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(4'b1101),
  parameter int                TMO_W    = 16,
  parameter logic [TMO_W-1:0]  TMO_TH   = TMO_W'(1000)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_en,
  input  logic              i_bit_vld,
  input  logic              i_bit_data,
  output logic              o_frm_vld,
  output logic [DATA_W-1:0] o_frm_data,
  output logic              o_frm_err,
  output logic [1:0]        o_err_type,
  output logic              o_busy
);

  localparam int FILL_W = $clog2(SYNC_W + 1);
  localparam int CNT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
`ifdef OWT_RX_PARITY_EN
  localparam int SR_W = DATA_W;
`else
  // Without parity the last data bit is delivered straight from the input, so the
  // shift register only ever needs to hold the earlier DATA_W-1 bits.
  localparam int SR_W = DATA_W - 1;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PAR} state_e;

  state_e              state_q, state_d;
  logic [SYNC_W-1:0]   sync_sr_q, sync_sr_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SR_W-1:0]     data_sr_q, data_sr_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                frm_vld_q, frm_vld_d;
  logic                frm_err_q, frm_err_d;
  logic [1:0]          err_type_q, err_type_d;
  logic [DATA_W-1:0]   frm_data_q, frm_data_d;
  logic                busy_q, busy_d;

  logic                bit_acc;
  logic [SYNC_W-1:0]   sync_shift;
  logic [TMO_W-1:0]    tmo_inc;
  logic                tmo_hit;

  always_comb begin
    bit_acc    = i_bit_vld & i_rx_en;
    sync_shift = {sync_sr_q[SYNC_W-2:0], i_bit_data};
    tmo_inc    = tmo_q + 1'b1;
    // An accepted bit always beats the timeout in the same cycle.
    tmo_hit    = !bit_acc && (tmo_inc == TMO_TH);

    state_d    = state_q;
    sync_sr_d  = sync_sr_q;
    fill_d     = fill_q;
    bit_cnt_d  = bit_cnt_q;
    data_sr_d  = data_sr_q;
    tmo_d      = tmo_q;
    frm_vld_d  = 1'b0;
    frm_err_d  = 1'b0;
    err_type_d = err_type_q;
    frm_data_d = frm_data_q;

    if (!i_rx_en) begin
      state_d   = ST_IDLE;
      sync_sr_d = '0;
      fill_d    = '0;
      bit_cnt_d = '0;
      tmo_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tmo_d     = '0;
          bit_cnt_d = '0;
          if (bit_acc) begin
            // Sliding window: every accepted bit is a candidate end of the sync pattern.
            if ((sync_shift == SYNC_PAT) && (fill_q >= FILL_MAX - FILL_W'(1))) begin
              state_d   = ST_DATA;
              sync_sr_d = '0;
              fill_d    = '0;
            end else begin
              sync_sr_d = sync_shift;
              if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (bit_acc) begin
            tmo_d     = '0;
            data_sr_d = SR_W'({data_sr_q, i_bit_data});
            if (bit_cnt_q == CNT_LAST) begin
              bit_cnt_d = '0;
`ifdef OWT_RX_PARITY_EN
              state_d    = ST_PAR;
`else
              state_d    = ST_IDLE;
              frm_vld_d  = 1'b1;
              frm_data_d = {data_sr_q, i_bit_data};
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else if (tmo_hit) begin
            state_d    = ST_IDLE;
            tmo_d      = '0;
            bit_cnt_d  = '0;
            frm_err_d  = 1'b1;
            err_type_d = 2'b10;
          end else begin
            tmo_d = tmo_inc;
          end
        end
`ifdef OWT_RX_PARITY_EN
        ST_PAR: begin
          if (bit_acc) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
            // Even parity: data bits XOR parity bit must be zero.
            if (i_bit_data == ^data_sr_q) begin
              frm_vld_d  = 1'b1;
              frm_data_d = data_sr_q;
            end else begin
              frm_err_d  = 1'b1;
              err_type_d = 2'b01;
            end
          end else if (tmo_hit) begin
            state_d    = ST_IDLE;
            tmo_d      = '0;
            frm_err_d  = 1'b1;
            err_type_d = 2'b10;
          end else begin
            tmo_d = tmo_inc;
          end
        end
`endif
        default: begin
          state_d   = ST_IDLE;
          sync_sr_d = '0;
          fill_d    = '0;
          bit_cnt_d = '0;
          tmo_d     = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      sync_sr_q  <= '0;
      fill_q     <= '0;
      bit_cnt_q  <= '0;
      data_sr_q  <= '0;
      tmo_q      <= '0;
      frm_vld_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      err_type_q <= 2'b00;
      frm_data_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_sr_q  <= sync_sr_d;
      fill_q     <= fill_d;
      bit_cnt_q  <= bit_cnt_d;
      data_sr_q  <= data_sr_d;
      tmo_q      <= tmo_d;
      frm_vld_q  <= frm_vld_d;
      frm_err_q  <= frm_err_d;
      err_type_q <= err_type_d;
      frm_data_q <= frm_data_d;
      busy_q     <= busy_d;
    end
  end

  assign o_frm_vld  = frm_vld_q;
  assign o_frm_data = frm_data_q;
  assign o_frm_err  = frm_err_q;
  assign o_err_type = err_type_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_owt_rx_deframe.sv
// Purpose : directed bench for owt_rx_deframe (defaults, TMO_TH=100), parity on or off.
// Latency : every step drives inputs 1ns after a rising edge and samples 1ns after the next.
// Backpr. : not applicable; the bench offers at most one bit per cycle.
module tb_owt_rx_deframe;

`ifdef OWT_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_rx_en = 1'b0;
  logic       i_bit_vld = 1'b0;
  logic       i_bit_data = 1'b0;
  logic       o_frm_vld;
  logic [7:0] o_frm_data;
  logic       o_frm_err;
  logic [1:0] o_err_type;
  logic       o_busy;

  owt_rx_deframe #(.TMO_TH(16'd100)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rx_en   (i_rx_en),
    .i_bit_vld (i_bit_vld),
    .i_bit_data(i_bit_data),
    .o_frm_vld (o_frm_vld),
    .o_frm_data(o_frm_data),
    .o_frm_err (o_frm_err),
    .o_err_type(o_err_type),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       en;
    logic       vld;
    logic       dat;
    logic       e_vld;
    logic       e_err;
    logic [1:0] e_type;
    logic [7:0] e_data;
    logic       e_busy;
  } vec_t;

  vec_t       vq[$];
  logic [7:0] h_data = 8'h00;
  logic [1:0] h_type = 2'b00;
  int         n_cmp  = 0;
  int         n_bad  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Table helpers: expected data/type are the held values at the time of the step.
  function automatic void add(input logic en, input logic vld, input logic dat,
                              input logic e_vld, input logic e_err, input logic e_busy);
    vec_t v;
    v.en = en; v.vld = vld; v.dat = dat;
    v.e_vld = e_vld; v.e_err = e_err; v.e_busy = e_busy;
    v.e_type = h_type; v.e_data = h_data;
    vq.push_back(v);
  endfunction

  function automatic void add_sync();
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1);
  endfunction

  function automatic void add_data(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) add(1, 1, d[7-i], 0, 0, 1);
  endfunction

  // Data bits and completion; 'good' is the hand-computed parity verdict.
  function automatic void add_body(input logic [7:0] d, input logic par, input logic good);
    if (!PAR_EN) begin
      add_data(d, 7);
      h_data = d;
      add(1, 1, d[0], 1, 0, 0);
    end else begin
      add_data(d, 8);
      if (good) begin
        h_data = d;
        add(1, 1, par, 1, 0, 0);
      end else begin
        h_type = 2'b01;
        add(1, 1, par, 0, 1, 0);
      end
    end
  endfunction

  function automatic void add_frame(input logic [7:0] d, input logic par, input logic good);
    add_sync();
    add_body(d, par, good);
  endfunction

  task automatic tick(input logic en, input logic vld, input logic dat);
    i_rx_en = en; i_bit_vld = vld; i_bit_data = dat;
    @(posedge i_clk);
    #1;
    i_bit_vld = 1'b0;
  endtask

  task automatic send_sync();
    tick(1, 1, 1); tick(1, 1, 1); tick(1, 1, 0); tick(1, 1, 1);
  endtask

  task automatic send_bits(input logic [7:0] d, input int from, input int to);
    for (int i = from; i <= to; i++) tick(1, 1, d[7-i]);
  endtask

  logic flag;

  initial begin
    // Reset state
    #12;
    check("rst_vld",  {31'd0, o_frm_vld}, 32'd0);
    check("rst_err",  {31'd0, o_frm_err}, 32'd0);
    check("rst_type", {30'd0, o_err_type}, 32'd0);
    check("rst_data", {24'd0, o_frm_data}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    #10 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Vector table
    add(1, 0, 0, 0, 0, 0);
    if (PAR_EN) begin
      add_frame(8'hA5, 1'b1, 1'b0);          // bad parity, data stays 0x00
      add(1, 0, 0, 0, 0, 0);
    end
    add_frame(8'hA5, 1'b0, 1'b1);
    add(1, 0, 0, 0, 0, 0);
    add_frame(8'h3C, 1'b0, 1'b1);            // back-to-back frames, no idle gap
    add_frame(8'h81, 1'b0, 1'b1);
    add(1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);                   // noise 1,1,1,1,0 then sync closes on 6th bit
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1);
    add_body(8'h0F, 1'b0, 1'b1);
    add_sync();                              // rx_en dropped after 4 data bits
    add_data(8'hF0, 4);
    add(0, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add_frame(8'h81, 1'b0, 1'b1);
    add(0, 1, 1, 0, 0, 0);                   // sync bits with rx_en low are ignored
    add(0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      i_rx_en = vq[i].en; i_bit_vld = vq[i].vld; i_bit_data = vq[i].dat;
      @(posedge i_clk);
      #1;
      check($sformatf("vec%0d", i),
            {19'd0, o_frm_vld, o_frm_err, o_err_type, o_frm_data, o_busy},
            {19'd0, vq[i].e_vld, vq[i].e_err, vq[i].e_type, vq[i].e_data, vq[i].e_busy});
    end
    i_bit_vld = 1'b0;

    // Timeout: 3 data bits then silence; error 100 idle cycles later
    send_sync();
    send_bits(8'hE0, 0, 2);
    check("tmo_busy", {31'd0, o_busy}, 32'd1);
    flag = 1'b0;
    for (int k = 0; k < 99; k++) begin
      tick(1, 0, 0);
      if (o_frm_err || o_frm_vld || !o_busy) flag = 1'b1;
    end
    check("tmo_early", {31'd0, flag}, 32'd0);
    tick(1, 0, 0);
    check("tmo_err", {27'd0, o_frm_vld, o_frm_err, o_err_type, o_busy}, {27'd0, 5'b0_1_10_0});
    check("tmo_data", {24'd0, o_frm_data}, 32'h81);
    tick(1, 0, 0);
    check("tmo_pulse", {31'd0, o_frm_err}, 32'd0);

    // A bit in the cycle the count would reach the threshold wins
    send_sync();
    send_bits(8'h3C, 0, 0);
    for (int k = 0; k < 99; k++) tick(1, 0, 0);
    tick(1, 1, 0);
    check("edge_noerr", {30'd0, o_frm_err, o_busy}, 32'd1);
    send_bits(8'h3C, 2, 7);
    if (PAR_EN) tick(1, 1, 0);
    check("edge_frame", {22'd0, o_frm_vld, o_frm_err, o_frm_data}, {22'd0, 2'b10, 8'h3C});

    // Reset mid-frame
    send_sync();
    send_bits(8'hFF, 0, 2);
    check("mid_busy", {31'd0, o_busy}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst", {19'd0, o_frm_vld, o_frm_err, o_err_type, o_frm_data, o_busy}, 32'd0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    flag = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1, 1, 1);
      if (o_frm_vld || o_frm_err || o_busy) flag = 1'b1;
    end
    check("mid_nopulse", {31'd0, flag}, 32'd0);
    send_sync();
    send_bits(8'h5A, 0, 7);
    if (PAR_EN) tick(1, 1, 0);
    check("post_rst", {22'd0, o_frm_vld, o_frm_err, o_frm_data}, {22'd0, 2'b10, 8'h5A});
    tick(1, 0, 0);
    check("post_rst_idle", {30'd0, o_frm_vld, o_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
